// File: rtl/pat_data_buf.sv
// Multi-entry cyclic pattern data buffer for the blitter datapath.
// Optional output rotation is enabled by defining PATDATA_ROT_EN.
module pat_data_buf #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RESETL,
  input  logic [WIDTH-1:0] ID,
  input  logic             LDPATL,
  input  logic             LDLENL,
  input  logic             LDROTL,
  input  logic             PATRSTL,
  input  logic             STEP,
  output logic [WIDTH-1:0] PATD,
  output logic             PATWRAP,
  output logic             PATVALID
);

  localparam int unsigned PTRW = $clog2(DEPTH);
  localparam int unsigned ROTW = $clog2(WIDTH);

  logic [WIDTH-1:0] entry_q [DEPTH];
  logic [WIDTH-1:0] entry_d [DEPTH];
  logic [PTRW-1:0]  wptr_q, wptr_d;
  logic [PTRW-1:0]  rptr_q, rptr_d;
  logic [PTRW-1:0]  len_q, len_d;
  logic             wrap_q, wrap_d;
  logic             valid_q, valid_d;

`ifdef PATDATA_ROT_EN
  logic [ROTW-1:0]    rot_q, rot_d;
  logic [2*WIDTH-1:0] rot_dbl;
`else
  logic               unused_ldrotl;
`endif

  always_comb begin
    entry_d = entry_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    len_d   = len_q;
    wrap_d  = 1'b0;
    valid_d = valid_q;
    // Restart outranks length load, which outranks the data-path actions.
    if (!PATRSTL) begin
      wptr_d  = '0;
      rptr_d  = '0;
      valid_d = 1'b0;
    end else if (!LDLENL) begin
      len_d   = ID[PTRW-1:0];
      valid_d = 1'b0;
      if (wptr_q > len_d) wptr_d = '0;
      if (rptr_q > len_d) rptr_d = '0;
    end else begin
      if (!LDPATL) begin
        entry_d[wptr_q] = ID;
        if (wptr_q == len_q) begin
          wptr_d  = '0;
          valid_d = 1'b1;
        end else begin
          wptr_d = wptr_q + 1'b1;
        end
      end
      if (STEP) begin
        if (rptr_q == len_q) begin
          rptr_d = '0;
          wrap_d = 1'b1;
        end else begin
          rptr_d = rptr_q + 1'b1;
        end
      end
    end
  end

`ifdef PATDATA_ROT_EN
  always_comb begin
    rot_d = rot_q;
    if (!LDROTL) rot_d = ID[ROTW-1:0];
  end

  // Left rotate: upper half of the doubled word shifted by ROT.
  assign rot_dbl = {entry_q[rptr_q], entry_q[rptr_q]} << rot_q;
  assign PATD    = rot_dbl[2*WIDTH-1:WIDTH];

  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) rot_q <= '0;
    else         rot_q <= rot_d;
  end
`else
  assign unused_ldrotl = LDROTL;
  assign PATD          = entry_q[rptr_q];
`endif

  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      for (int unsigned i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      len_q   <= PTRW'(DEPTH - 1);
      wrap_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      len_q   <= len_d;
      wrap_q  <= wrap_d;
      valid_q <= valid_d;
    end
  end

  assign PATWRAP  = wrap_q;
  assign PATVALID = valid_q;

endmodule

// File: tb/tb_pat_data_buf.sv
// Scoreboard bench for pat_data_buf: directed scenarios plus random traffic
// against a behavioural model; honours PATDATA_ROT_EN like the design.
module tb_pat_data_buf;
  localparam int unsigned W = 8;
  localparam int unsigned D = 4;

  logic         CLK = 1'b0;
  logic         RESETL = 1'b1;
  logic [W-1:0] ID = '0;
  logic         LDPATL = 1'b1, LDLENL = 1'b1, LDROTL = 1'b1, PATRSTL = 1'b1;
  logic         STEP = 1'b0;
  logic [W-1:0] PATD;
  logic         PATWRAP, PATVALID;

  pat_data_buf #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK(CLK), .RESETL(RESETL), .ID(ID), .LDPATL(LDPATL), .LDLENL(LDLENL),
    .LDROTL(LDROTL), .PATRSTL(PATRSTL), .STEP(STEP), .PATD(PATD),
    .PATWRAP(PATWRAP), .PATVALID(PATVALID)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [W-1:0] patd;
    logic         wrap;
    logic         valid;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_cycle  = 0;

  // Behavioural model state
  logic [W-1:0] mem [D];
  int unsigned  wp, rp, len, rot;
  bit           m_wrap, m_valid;

  function automatic void model_reset();
    for (int i = 0; i < int'(D); i++) mem[i] = '0;
    wp = 0; rp = 0; len = D - 1; rot = 0; m_wrap = 0; m_valid = 0;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    logic [W-1:0] src;
    src = mem[rp];
    for (int i = 0; i < int'(W); i++) e.patd[i] = src[(i + int'(W) - int'(rot)) % int'(W)];
    e.wrap  = m_wrap;
    e.valid = m_valid;
    return e;
  endfunction

  function automatic void model_edge(logic rstl, logic lenl, logic patl, logic rotl,
                                     logic step, logic [W-1:0] id);
    m_wrap = 0;
    if (!rstl) begin
      wp = 0; rp = 0; m_valid = 0;
    end else if (!lenl) begin
      len = int'(id) % D;
      if (wp > len) wp = 0;
      if (rp > len) rp = 0;
      m_valid = 0;
    end else begin
      if (!patl) begin
        mem[wp] = id;
        if (wp == len) begin wp = 0; m_valid = 1; end
        else wp = wp + 1;
      end
      if (step) begin
        if (rp == len) begin rp = 0; m_wrap = 1; end
        else rp = rp + 1;
      end
    end
`ifdef PATDATA_ROT_EN
    if (!rotl) rot = int'(id) % W;
`else
    if (!rotl) rot = 0;
`endif
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got patd=%h wrap=%b valid=%b, expected patd=%h wrap=%b valid=%b",
                  name, act.patd, act.wrap, act.valid, exp.patd, exp.wrap, exp.valid);
  endtask

  task automatic cyc(input logic rstl, input logic lenl, input logic patl,
                     input logic rotl, input logic step, input logic [W-1:0] id);
    PATRSTL = rstl; LDLENL = lenl; LDPATL = patl; LDROTL = rotl; STEP = step; ID = id;
    @(posedge CLK);
    model_edge(rstl, lenl, patl, rotl, step, id);
    sb.push_back(model_out());
    #1;
    PATRSTL = 1'b1; LDLENL = 1'b1; LDPATL = 1'b1; LDROTL = 1'b1; STEP = 1'b0;
  endtask

  task automatic load(input logic [W-1:0] id); cyc(1, 1, 0, 1, 0, id); endtask
  task automatic step_once();                  cyc(1, 1, 1, 1, 1, '0); endtask
  task automatic idle();                       cyc(1, 1, 1, 1, 0, '0); endtask

  task automatic do_reset();
    exp_t z;
    z = '0;
    @(negedge CLK);
    #1 RESETL = 1'b0;
    #1 check("reset_async", {PATD, PATWRAP, PATVALID}, z);
    model_reset();
    @(posedge CLK);
    sb.push_back(model_out());
    #1 RESETL = 1'b1;
  endtask

  // Monitor: outputs are presented every cycle; compare at the falling edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      n_cycle++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("cycle%0d", n_cycle), {PATD, PATWRAP, PATVALID}, e);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [W-1:0] rot_exp;
    model_reset();
    do_reset();

    // Basic fill and cyclic read at default length
    load(8'h11); load(8'h22); load(8'h33); load(8'h44);
    for (int i = 0; i < 5; i++) step_once();
    idle();

    // Reset with entries loaded, then confirm length is back to DEPTH-1
    do_reset();
    load(8'h01); load(8'h02); load(8'h03); load(8'h04);
    idle();

    // Two-entry pattern
    cyc(1, 0, 1, 1, 0, 8'h01);
    load(8'hA5); load(8'h5A);
    for (int i = 0; i < 6; i++) step_once();

    // Simultaneous write and step with wptr == rptr == 2
    cyc(0, 1, 1, 1, 0, '0);
    cyc(1, 0, 1, 1, 0, 8'h03);
    load(8'h01); load(8'h02);
    step_once(); step_once();
    cyc(1, 1, 0, 1, 1, 8'hC3);
    idle();
    cyc(0, 1, 1, 1, 0, '0);
    step_once(); step_once();
    idle();

    // Everything asserted on one edge: restart wins
    cyc(0, 0, 0, 1, 1, 8'h00);
    idle();

    // Single-entry pattern with rotation
    cyc(1, 0, 1, 1, 0, 8'h00);
    load(8'h81);
    cyc(1, 1, 1, 0, 0, 8'h03);
    idle();
`ifdef PATDATA_ROT_EN
    rot_exp = 8'h0C;
`else
    rot_exp = 8'h81;
`endif
    n_checks++;
    if (PATD === rot_exp) n_pass++;
    else $display("FAIL rot_example: got patd=%h, expected %h", PATD, rot_exp);
    for (int i = 0; i < 3; i++) step_once();
    cyc(1, 1, 1, 0, 0, 8'h00);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      r = $urandom_range(0, 199);
      if (r == 0) do_reset();
      else cyc(r < 6 ? 1'b0 : 1'b1,
               (r >= 6 && r < 14) ? 1'b0 : 1'b1,
               logic'($urandom_range(0, 1)),
               ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
               ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
               W'($urandom));
    end
    idle();

    @(negedge CLK);
    #1;
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
